// File: rtl/tone_src_pkg.sv
// Shared types and constants for the tone_src test-tone generator.
package tone_src_pkg;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_ZERO   = 2'd3
  } wave_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Square levels sit at half scale so the waveform has headroom through a filter.
  function automatic int sq_pos_amp(input int sample_width);
    return (32'sd1 <<< (sample_width - 32'sd2)) - 32'sd1;
  endfunction

  function automatic int sq_neg_amp(input int sample_width);
    return -(32'sd1 <<< (sample_width - 32'sd2));
  endfunction

endpackage

// File: rtl/tone_wave_shaper.sv
// Combinational mapping from accumulator phase to a signed sample for each wave shape.
module tone_wave_shaper
  import tone_src_pkg::*;
#(
  parameter int PHASE_WIDTH  = 32,
  parameter int SAMPLE_WIDTH = 8
) (
  input  logic [PHASE_WIDTH-1:0]         i_phase,
  input  wave_e                          i_wave,
  output logic signed [SAMPLE_WIDTH-1:0] o_sample
);

  localparam logic [SAMPLE_WIDTH-1:0] SQ_POS = SAMPLE_WIDTH'(sq_pos_amp(SAMPLE_WIDTH));
  localparam logic [SAMPLE_WIDTH-1:0] SQ_NEG = SAMPLE_WIDTH'(sq_neg_amp(SAMPLE_WIDTH));

  logic                    w_msb;
  logic [SAMPLE_WIDTH-1:0] w_u;
  logic [SAMPLE_WIDTH-1:0] w_f;
  logic                    w_unused_low;

  assign w_msb        = i_phase[PHASE_WIDTH-1];
  assign w_u          = i_phase[PHASE_WIDTH-2 -: SAMPLE_WIDTH];
  assign w_f          = w_msb ? ~w_u : w_u;
  assign w_unused_low = ^i_phase[PHASE_WIDTH-SAMPLE_WIDTH-2:0];

  // Offset-binary to two's complement is just an MSB flip for saw and triangle.
  always_comb begin
    o_sample = {SAMPLE_WIDTH{1'b0}};
    case (i_wave)
      WAVE_SQUARE: o_sample = w_msb ? SQ_NEG : SQ_POS;
      WAVE_SAW:    o_sample = {~w_msb, i_phase[PHASE_WIDTH-2 -: SAMPLE_WIDTH-1]};
      WAVE_TRI:    o_sample = {~w_f[SAMPLE_WIDTH-1], w_f[SAMPLE_WIDTH-2:0]};
      WAVE_ZERO:   o_sample = {SAMPLE_WIDTH{1'b0}};
      default:     o_sample = {SAMPLE_WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/tone_src.sv
// Test-tone source: phase accumulator with linear sweep, strobe divider and burst/continuous control.
module tone_src
  import tone_src_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8,
  parameter int PHASE_WIDTH  = 32,
  parameter int DIV_WIDTH    = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [PHASE_WIDTH-1:0]         cfg_phase_inc,
  input  logic [PHASE_WIDTH-1:0]         cfg_sweep_inc,
  input  logic [DIV_WIDTH-1:0]           cfg_div,
  input  logic [1:0]                     cfg_wave,
  input  logic [31:0]                    cfg_count,
  input  logic                           start,
  input  logic                           stop,
  output logic signed [SAMPLE_WIDTH-1:0] out,
  output logic                           out_valid,
  output logic                           busy,
  output logic                           done
);

  state_e                         r_state;
  state_e                         w_state_nxt;
  logic [PHASE_WIDTH-1:0]         r_phase;
  logic [PHASE_WIDTH-1:0]         r_inc;
  logic [PHASE_WIDTH-1:0]         r_sweep;
  logic [DIV_WIDTH-1:0]           r_div;
  logic [DIV_WIDTH-1:0]           r_div_cnt;
  wave_e                          r_wave;
  logic [31:0]                    r_count;
  logic [31:0]                    r_smp_cnt;
  logic signed [SAMPLE_WIDTH-1:0] r_out;
  logic                           r_out_valid;
  logic                           r_done;

  logic                           w_start;
  logic                           w_emit;
  logic                           w_tick;
  logic                           w_last;
  logic [31:0]                    w_smp_nxt;
  logic signed [SAMPLE_WIDTH-1:0] w_shaped;

  tone_wave_shaper #(
    .PHASE_WIDTH  (PHASE_WIDTH),
    .SAMPLE_WIDTH (SAMPLE_WIDTH)
  ) u_shaper (
    .i_phase  (r_phase),
    .i_wave   (r_wave),
    .o_sample (w_shaped)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; stop always wins over start and over burst completion.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop || w_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM-derived control strobes for the datapath.
  always_comb begin
    w_start   = 1'b0;
    w_emit    = 1'b0;
    w_tick    = 1'b0;
    w_smp_nxt = r_smp_cnt + 32'd1;
    case (r_state)
      ST_IDLE: w_start = start && !stop;
      ST_RUN: begin
        if (!stop) begin
          w_emit = (r_div_cnt == {DIV_WIDTH{1'b0}});
          w_tick = (r_div_cnt != {DIV_WIDTH{1'b0}});
        end else begin
          w_emit = 1'b0;
          w_tick = 1'b0;
        end
      end
      default: w_start = 1'b0;
    endcase
    w_last = w_emit && (r_count != 32'd0) && (w_smp_nxt == r_count);
  end

  // Configuration latch, accumulator, divider and sample counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase   <= {PHASE_WIDTH{1'b0}};
      r_inc     <= {PHASE_WIDTH{1'b0}};
      r_sweep   <= {PHASE_WIDTH{1'b0}};
      r_div     <= {DIV_WIDTH{1'b0}};
      r_div_cnt <= {DIV_WIDTH{1'b0}};
      r_wave    <= WAVE_SQUARE;
      r_count   <= 32'd0;
      r_smp_cnt <= 32'd0;
    end else if (w_start) begin
      r_phase   <= {PHASE_WIDTH{1'b0}};
      r_inc     <= cfg_phase_inc;
      r_sweep   <= cfg_sweep_inc;
      r_div     <= cfg_div;
      r_div_cnt <= {DIV_WIDTH{1'b0}};
      r_wave    <= wave_e'(cfg_wave);
      r_count   <= cfg_count;
      r_smp_cnt <= 32'd0;
    end else if (w_emit) begin
      r_phase   <= r_phase + r_inc;
      r_inc     <= r_inc + r_sweep;
      r_div_cnt <= r_div;
      r_smp_cnt <= w_smp_nxt;
    end else if (w_tick) begin
      r_div_cnt <= r_div_cnt - {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Registered sample output; the value holds between strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out       <= {SAMPLE_WIDTH{1'b0}};
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_out_valid <= w_emit;
      r_done      <= w_last;
      if (w_emit) begin
        r_out <= w_shaped;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign done      = r_done;
  assign busy      = (r_state == ST_RUN);

endmodule

// File: tb/tb_tone_src.sv
// Self-checking bench for tone_src: directed test-plan bursts plus randomized bursts against a closed-form model.
module tb_tone_src;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [31:0]       cfg_phase_inc;
  logic [31:0]       cfg_sweep_inc;
  logic [15:0]       cfg_div;
  logic [1:0]        cfg_wave;
  logic [31:0]       cfg_count;
  logic              start;
  logic              stop;
  logic signed [7:0] out;
  logic              out_valid;
  logic              busy;
  logic              done;

  int vectors     = 0;
  int miscompares = 0;

  tone_src #(
    .SAMPLE_WIDTH (8),
    .PHASE_WIDTH  (32),
    .DIV_WIDTH    (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cfg_phase_inc (cfg_phase_inc),
    .cfg_sweep_inc (cfg_sweep_inc),
    .cfg_div       (cfg_div),
    .cfg_wave      (cfg_wave),
    .cfg_count     (cfg_count),
    .start         (start),
    .stop          (stop),
    .out           (out),
    .out_valid     (out_valid),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Sample k of a burst: phase_k = k*inc + sweep*k*(k-1)/2 (mod 2^32), then shaped arithmetically.
  function automatic logic [7:0] model(input logic [31:0] inc, input logic [31:0] sweep,
                                       input logic [1:0] wave, input int k);
    logic [63:0] kk;
    logic [63:0] ph64;
    logic [31:0] ph;
    int          u;
    int          f;
    int          r;
    kk   = 64'(k);
    ph64 = kk * {32'd0, inc} + {{32{sweep[31]}}, sweep} * ((kk * (kk - 64'd1)) / 64'd2);
    ph   = ph64[31:0];
    case (wave)
      2'd0: r = (ph < 32'h8000_0000) ? 63 : -64;
      2'd1: r = int'(ph >> 24) - 128;
      2'd2: begin
        u = int'((ph >> 23) & 32'd255);
        f = (ph >= 32'h8000_0000) ? (255 - u) : u;
        r = f - 128;
      end
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic logic [31:0] sx(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  // One burst: start at the current (off-edge) time, check every cycle until done or stop.
  task automatic run_burst(input logic [31:0] inc, input logic [31:0] sweep, input logic [15:0] div,
                           input logic [1:0] wave, input logic [31:0] count, input int stop_after);
    int          d;
    int          n_smp;
    int          last_c;
    int          j;
    bit          emit;
    bit          fin;
    logic [7:0]  exp_out;
    cfg_phase_inc = inc;
    cfg_sweep_inc = sweep;
    cfg_div       = div;
    cfg_wave      = wave;
    cfg_count     = count;
    start         = 1'b1;
    stop          = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_phase_inc = $urandom;
    cfg_sweep_inc = $urandom;
    cfg_div       = 16'($urandom);
    cfg_wave      = 2'($urandom);
    cfg_count     = $urandom_range(1, 3);
    chk("busy_rise", {31'd0, busy}, 32'd1);
    chk("no_valid_at_start", {31'd0, out_valid}, 32'd0);
    d      = int'(div) + 1;
    n_smp  = (count != 32'd0) ? int'(count) : stop_after;
    last_c = (n_smp - 1) * d + 1;
    exp_out = 8'd0;
    for (int c = 1; c <= last_c; c++) begin
      @(posedge clk); #1;
      emit = ((c - 1) % d) == 0;
      j    = (c - 1) / d;
      fin  = (count != 32'd0) && (c == last_c);
      chk("out_valid", {31'd0, out_valid}, {31'd0, emit});
      if (emit) exp_out = model(inc, sweep, wave, j);
      chk(emit ? "out_sample" : "out_hold", sx(out), sx(exp_out));
      chk("done", {31'd0, done}, {31'd0, fin});
      chk("busy", {31'd0, busy}, {31'd0, !fin});
    end
    if (count == 32'd0) begin
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      chk("stop_no_valid", {31'd0, out_valid}, 32'd0);
      chk("stop_no_done", {31'd0, done}, 32'd0);
      chk("stop_busy", {31'd0, busy}, 32'd0);
      chk("stop_out_hold", sx(out), sx(exp_out));
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    start         = 1'b0;
    stop          = 1'b0;
    cfg_phase_inc = 32'd0;
    cfg_sweep_inc = 32'd0;
    cfg_div       = 16'd0;
    cfg_wave      = 2'd0;
    cfg_count     = 32'd0;
    #1;
    chk("rst_out", sx(out), 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_valid", {31'd0, out_valid}, 32'd0);

    // Test-plan scenarios, chained so each start lands in the cycle done is high.
    run_burst(32'h1000_0000, 32'd0, 16'd0, 2'd0, 32'd32, 0);
    run_burst(32'h0100_0000, 32'd0, 16'd3, 2'd1, 32'd4, 0);
    run_burst(32'h2000_0000, 32'd0, 16'd0, 2'd2, 32'd8, 0);
    run_burst(32'd0, 32'h0100_0000, 16'd0, 2'd1, 32'd5, 0);
    run_burst(32'h1000_0000, 32'd0, 16'd0, 2'd0, 32'd0, 5);
    @(posedge clk); #1;
    chk("after_stop_idle", {31'd0, out_valid}, 32'd0);
    run_burst(32'h1000_0000, 32'd0, 16'd0, 2'd0, 32'd1, 0);
    chk("restart_first", sx(out), 32'd63);

    // Randomized bursts, including sweeps and continuous mode with stop.
    for (int n = 0; n < 24; n++) begin
      run_burst($urandom, $urandom, 16'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 12)),
                $urandom_range(1, 9));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        chk("gap_valid", {31'd0, out_valid}, 32'd0);
      end
    end

    // Asynchronous reset in the middle of a burst.
    cfg_phase_inc = 32'h1000_0000;
    cfg_sweep_inc = 32'd0;
    cfg_div       = 16'd1;
    cfg_wave      = 2'd0;
    cfg_count     = 32'd20;
    start         = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out", sx(out), 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
    end
    start = 1'b1;
    stop  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("start_stop_valid", {31'd0, out_valid}, 32'd0);
      chk("start_stop_busy", {31'd0, busy}, 32'd0);
    end
    start = 1'b0;
    stop  = 1'b0;
    run_burst(32'h0100_0000, 32'd0, 16'd2, 2'd1, 32'd3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
